pe_group_ctrl: RTL and testbench

Sequencer for one pe_group convolution datapath. On `start`, it loads one weight set from weight BRAM and pulses `weight_en`. It then streams `cfg_rows` × `cfg_cols` ifmap windows from ifmap BRAM, drives `calculate_en` aligned to full windows, and flags each valid `groupsum_out*` with row/column tags for the writeback stage. It sits between the layer scheduler (`start`/`done`) and pe_group plus its BRAMs.

---
 rtl/pe_group_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_pe_group_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_group_ctrl.sv
// rtl/pe_group_ctrl.sv - weight load, ifmap read and output tagging sequencer for one pe_group
// Optional feature macro: PE_CTRL_PERF_EN adds calc/busy cycle counters.
module pe_group_ctrl #(
  parameter int ADDR_W   = 12,
  parameter int DIM_W    = 8,
  parameter int BRAM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        cfg_layer_i,
  input  logic [DIM_W-1:0]  cfg_rows_i,
  input  logic [DIM_W-1:0]  cfg_cols_i,
  input  logic [ADDR_W-1:0] cfg_if_base_i,
  input  logic [ADDR_W-1:0] cfg_row_stride_i,
  input  logic [ADDR_W-1:0] cfg_w_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              cfg_err_o,
  output logic [3:0]        layer_o,
  output logic              w_rd_en_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic              weight_en_o,
  output logic              if_rd_en_o,
  output logic [ADDR_W-1:0] if_addr_o,
  output logic              calculate_en_o,
  output logic              out_valid_o,
  output logic [DIM_W-1:0]  out_row_o,
  output logic [DIM_W-1:0]  out_col_o
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_calc_cycles_o,
  output logic [31:0]       perf_busy_cycles_o
`endif
);

  // Tag pipeline: BRAM + ifmap register to calculate_en, then prod/half/groupsum to out_valid.
  localparam int CAL_IDX = BRAM_LAT;
  localparam int OUT_IDX = BRAM_LAT + 3;
  localparam int PIPE    = BRAM_LAT + 4;
  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_WARM, S_CALC, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [DIM_W-1:0]    cnt_q, row_q, rows_q, cols_q;
  logic [3:0]          layer_q;
  logic [ADDR_W-1:0]   stride_q, w_addr_q, row_base_q, addr_q;
  logic [PIPE-1:0]     vld_q;
  logic [DIM_W-1:0]    trow_q [PIPE];
  logic [DIM_W-1:0]    tcol_q [PIPE];

  logic                legal, accept, calc, phase_end, row_next;
  logic [DIM_W-1:0]    warm_last;
  logic [ADDR_W-1:0]   step;

  always_comb begin
    legal = (cfg_layer_i == 4'd1 || cfg_layer_i == 4'd3 || cfg_layer_i == 4'd4) &&
            (cfg_rows_i != '0) && (cfg_cols_i != '0);
    case (layer_q)
      4'd1:    warm_last = DIM_W'(3);
      4'd3:    warm_last = DIM_W'(1);
      default: warm_last = '0;
    endcase
    step = (layer_q == 4'd4) ? ADDR_W'(2) : ADDR_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    cfg_err_o   = 1'b0;
    busy_o      = (state_q != S_IDLE);
    w_rd_en_o   = 1'b0;
    weight_en_o = 1'b0;
    if_rd_en_o  = 1'b0;
    calc        = 1'b0;
    done_o      = 1'b0;
    phase_end   = 1'b0;
    row_next    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !rst_i) begin
          if (legal) begin
            accept  = 1'b1;
            busy_o  = 1'b1;
            state_d = S_WLOAD;
          end else begin
            cfg_err_o = 1'b1;
          end
        end
      end
      S_WLOAD: begin
        w_rd_en_o   = (cnt_q == '0);
        weight_en_o = (cnt_q == DIM_W'(2));
        if (cnt_q == DIM_W'(2)) begin
          phase_end = 1'b1;
          state_d   = S_WARM;
        end
      end
      S_WARM: begin
        if_rd_en_o = 1'b1;
        if (cnt_q == warm_last) begin
          phase_end = 1'b1;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if_rd_en_o = 1'b1;
        calc       = 1'b1;
        if (cnt_q == cols_q - DIM_ONE) begin
          phase_end = 1'b1;
          if (row_q == rows_q - DIM_ONE) begin
            state_d = S_DRAIN;
          end else begin
            row_next = 1'b1;
            state_d  = S_WARM;
          end
        end
      end
      S_DRAIN: begin
        if (vld_q == '0) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      layer_q    <= '0;
      stride_q   <= '0;
      w_addr_q   <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      vld_q      <= '0;
      for (int i = 0; i < PIPE; i++) begin
        trow_q[i] <= '0;
        tcol_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        layer_q    <= cfg_layer_i;
        rows_q     <= cfg_rows_i;
        cols_q     <= cfg_cols_i;
        stride_q   <= cfg_row_stride_i;
        w_addr_q   <= cfg_w_addr_i;
        row_base_q <= cfg_if_base_i;
        addr_q     <= cfg_if_base_i;
        row_q      <= '0;
        cnt_q      <= '0;
      end else if (phase_end) begin
        cnt_q <= '0;
      end else if (state_q == S_WLOAD || state_q == S_WARM || state_q == S_CALC) begin
        cnt_q <= cnt_q + DIM_ONE;
      end
      if (if_rd_en_o) addr_q <= addr_q + step;
      // The next row restarts from its own base, overriding the per-read increment.
      if (row_next) begin
        row_q      <= row_q + DIM_ONE;
        row_base_q <= row_base_q + stride_q;
        addr_q     <= row_base_q + stride_q;
      end
      vld_q     <= {vld_q[PIPE-2:0], calc};
      trow_q[0] <= calc ? row_q : '0;
      tcol_q[0] <= calc ? cnt_q : '0;
      for (int i = 1; i < PIPE; i++) begin
        trow_q[i] <= trow_q[i-1];
        tcol_q[i] <= tcol_q[i-1];
      end
    end
  end

  assign layer_o        = layer_q;
  assign w_addr_o       = w_rd_en_o ? w_addr_q : '0;
  assign if_addr_o      = if_rd_en_o ? addr_q : '0;
  assign calculate_en_o = vld_q[CAL_IDX];
  assign out_valid_o    = vld_q[OUT_IDX];
  assign out_row_o      = trow_q[OUT_IDX];
  assign out_col_o      = tcol_q[OUT_IDX];

`ifdef PE_CTRL_PERF_EN
  logic [31:0] perf_calc_q, perf_busy_q;

  // The start cycle itself is busy, so the busy counter restarts at one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_calc_q <= '0;
      perf_busy_q <= '0;
    end else if (accept) begin
      perf_calc_q <= '0;
      perf_busy_q <= 32'd1;
    end else begin
      if (calculate_en_o && perf_calc_q != '1) perf_calc_q <= perf_calc_q + 32'd1;
      if (state_q != S_IDLE && perf_busy_q != '1) perf_busy_q <= perf_busy_q + 32'd1;
    end
  end

  assign perf_calc_cycles_o = perf_calc_q;
  assign perf_busy_cycles_o = perf_busy_q;
`endif

endmodule

// File: tb/tb_pe_group_ctrl.sv
// tb/tb_pe_group_ctrl.sv - scoreboard bench for pe_group_ctrl
module tb_pe_group_ctrl;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [3:0]    cfg_layer;
  logic [DW-1:0] cfg_rows, cfg_cols;
  logic [AW-1:0] cfg_if_base, cfg_row_stride, cfg_w_addr;
  logic          busy, done, cfg_err, w_rd_en, weight_en, if_rd_en, calculate_en, out_valid;
  logic [3:0]    layer;
  logic [AW-1:0] w_addr, if_addr;
  logic [DW-1:0] out_row, out_col;
`ifdef PE_CTRL_PERF_EN
  logic [31:0]   perf_calc, perf_busy;
`endif

  pe_group_ctrl #(.ADDR_W(AW), .DIM_W(DW), .BRAM_LAT(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_layer_i(cfg_layer),
    .cfg_rows_i(cfg_rows), .cfg_cols_i(cfg_cols), .cfg_if_base_i(cfg_if_base),
    .cfg_row_stride_i(cfg_row_stride), .cfg_w_addr_i(cfg_w_addr),
    .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err), .layer_o(layer),
    .w_rd_en_o(w_rd_en), .w_addr_o(w_addr), .weight_en_o(weight_en),
    .if_rd_en_o(if_rd_en), .if_addr_o(if_addr), .calculate_en_o(calculate_en),
    .out_valid_o(out_valid), .out_row_o(out_row), .out_col_o(out_col)
`ifdef PE_CTRL_PERF_EN
    , .perf_calc_cycles_o(perf_calc), .perf_busy_cycles_o(perf_busy)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int busy_lo = 1;
  int busy_hi = 0;
  int abort_c = 32'h7fffffff;
  logic mon_en = 1'b0;

  // kinds: 0 w_rd, 1 weight_en, 2 if_rd, 3 calculate_en, 4 out_valid, 5 done, 6 cfg_err
  typedef struct {int k; int c; int a; int b;} ev_t;
  ev_t q[$];

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  function automatic void push(int k, int c, int a, int b);
    ev_t e;
    e = '{k, c, a, b};
    if (c < abort_c) q.push_back(e);
  endfunction

  function automatic void see(int k, string n, int a, int b);
    int idx;
    idx = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].k == k) begin
        idx = i;
        break;
      end
    end
    total++;
    if (idx < 0) begin
      bad++;
      $display("FAIL %s: unexpected assertion at cycle %0d, required none", n, cyc);
    end else begin
      chk({n, "_cycle"}, cyc, q[idx].c);
      chk({n, "_a"}, a, q[idx].a);
      chk({n, "_b"}, b, q[idx].b);
      q.delete(idx);
    end
  endfunction

  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (w_rd_en)      see(0, "w_rd", int'(w_addr), 0);
      if (weight_en)    see(1, "weight_en", 0, 0);
      if (if_rd_en)     see(2, "if_rd", int'(if_addr), 0);
      if (calculate_en) see(3, "calculate_en", 0, 0);
      if (out_valid)    see(4, "out_tag", int'(out_row), int'(out_col));
      if (done)         see(5, "done", 0, 0);
      if (cfg_err)      see(6, "cfg_err", 0, 0);
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    end
  end

  task automatic check_idle(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_layer"}, layer, 0);
    chk({tag, "_w_rd"}, w_rd_en, 0);
    chk({tag, "_weight_en"}, weight_en, 0);
    chk({tag, "_if_rd"}, if_rd_en, 0);
    chk({tag, "_if_addr"}, if_addr, 0);
    chk({tag, "_cal"}, calculate_en, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
  endtask

  // Called on a negedge; start is presented in cycle t.
  task automatic run(input int ly, input int rows, input int cols, input int base,
                     input int stride, input int wa, input int abort_after, input int repulse);
    int t, w, st, k, a, d, stop;
    bit legal;
    t = cyc;
    abort_c = (abort_after > 0) ? t + abort_after : 32'h7fffffff;
    legal = (ly == 1 || ly == 3 || ly == 4) && rows > 0 && cols > 0;
    cfg_layer = ly[3:0];
    cfg_rows = rows[DW-1:0];
    cfg_cols = cols[DW-1:0];
    cfg_if_base = base[AW-1:0];
    cfg_row_stride = stride[AW-1:0];
    cfg_w_addr = wa[AW-1:0];
    start = 1'b1;
    if (!legal) begin
      push(6, t, 0, 0);
      busy_lo = 1;
      busy_hi = 0;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      return;
    end
    w = (ly == 1) ? 4 : (ly == 3) ? 2 : 1;
    st = (ly == 4) ? 2 : 1;
    push(0, t + 1, wa, 0);
    push(1, t + 3, 0, 0);
    k = 0;
    for (int r = 0; r < rows; r++) begin
      a = (base + r * stride) & 32'hfff;
      for (int i = 0; i < w + cols; i++) begin
        push(2, t + 4 + k, a, 0);
        if (i >= w) begin
          push(3, t + 4 + k + 2, 0, 0);
          push(4, t + 4 + k + 5, r, i - w);
        end
        a = (a + st) & 32'hfff;
        k++;
      end
    end
    d = t + 4 + k - 1 + 5 + 1;
    push(5, d, 0, 0);
    busy_lo = t;
    busy_hi = (d < abort_c) ? d : abort_c - 1;
    stop = (abort_after > 0) ? abort_c : d + 2;
    while (cyc < stop) begin
      @(negedge clk);
      start = 1'b0;
      rst = 1'b0;
      if (abort_after > 0 && cyc == abort_c - 1) rst = 1'b1;
      if (abort_after > 0 && cyc == abort_c) begin
        #2;
        check_idle("abort");
        chk("abort_cfg_err", cfg_err, 0);
      end
      if (repulse != 0 && (cyc == t + 6 || cyc == d)) begin
        start = 1'b1;
        cfg_layer = 4'd3;
        cfg_cols = 8'd5;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_layer = '0;
    cfg_rows = '0;
    cfg_cols = '0;
    cfg_if_base = '0;
    cfg_row_stride = '0;
    cfg_w_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check_idle("reset");
    chk("reset_cfg_err", cfg_err, 0);
    mon_en = 1'b1;
    @(negedge clk);

    run(1, 1, 3, 'h010, 0, 'h055, 0, 0);
    run(4, 2, 2, 'h100, 'h040, 'h0aa, 0, 0);
    chk("layer_reg", layer, 4);
    run(3, 1, 1, 'h200, 0, 'h001, 0, 0);
    run(2, 1, 1, 'h000, 0, 'h000, 0, 0);
    run(1, 1, 0, 'h000, 0, 'h000, 0, 0);
    run(1, 0, 1, 'h000, 0, 'h000, 0, 0);
    run(1, 1, 3, 'h010, 0, 'h055, 10, 0);
    run(3, 2, 1, 'h020, 'h010, 'h077, 0, 0);
    run(1, 1, 3, 'h010, 0, 'h055, 0, 1);
`ifdef PE_CTRL_PERF_EN
    chk("perf_calc", perf_calc, 3);
    chk("perf_busy", perf_busy, 17);
`endif
    run(4, 1, 1, 'hffe, 0, 'hfff, 0, 0);

    repeat (10) @(negedge clk);
    chk("pending_events", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
